// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for the L2 port arbiter
package l2_arb_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } l2_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } l2_rsp_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// rtl/l2_port_arbiter_if.sv - master-side OBI bundle plus the SRAM port of the L2 arbiter
interface l2_port_arbiter_if #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 12
);
    logic [NUM_MST-1:0]             m_req_i;
    logic [NUM_MST-1:0]             m_we_i;
    logic [NUM_MST-1:0][3:0]        m_be_i;
    logic [NUM_MST-1:0][ADDR_W-1:0] m_addr_i;
    logic [NUM_MST-1:0][31:0]       m_wdata_i;
    logic [NUM_MST-1:0]             m_gnt_o;
    logic [NUM_MST-1:0]             m_rvalid_o;
    logic [NUM_MST-1:0][31:0]       m_rdata_o;
    logic [NUM_MST-1:0]             m_err_o;
    logic                           mem_req_o;
    logic                           mem_we_o;
    logic [3:0]                     mem_be_o;
    logic [MEM_AW-1:0]              mem_addr_o;
    logic [31:0]                    mem_wdata_o;
    logic [31:0]                    mem_rdata_i;

    modport slave (
        input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, mem_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, mem_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/l2_rr_picker.sv
// rtl/l2_rr_picker.sv - combinational round-robin / fixed-priority winner selection
module l2_rr_picker #(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               fix_prio,
    output logic [NUM_MST-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan starts at 0 in fixed mode, at rr_ptr otherwise, wrapping past NUM_MST-1.
        for (int k = 0; k < NUM_MST; k++) begin
            int j;
            j = fix_prio ? k : int'(rr_ptr) + k;
            if (j >= NUM_MST) j = j - NUM_MST;
            if (req[j] && !valid) begin
                valid = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
        if (valid) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - shares the single-port L2 SRAM between NUM_MST OBI masters
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int               NUM_MST   = 2,
    parameter int               ADDR_W    = 32,
    parameter int               MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fix_prio_i,
    l2_port_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int MAW   = $clog2(MEM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_MST - 1);
    localparam logic [ADDR_W-2:0] MEM_WORDS_L = (ADDR_W-1)'(MEM_WORDS);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_MST-1:0] win_gnt;
    logic               win_valid;
    logic               grant;
    logic               in_range;
    logic [ADDR_W-1:0]  off;
    logic               unused_bits;
    l2_req_t            sel;

    logic               rsp_valid;
    logic [IDX_W-1:0]   rsp_idx;
    logic               rsp_err;
    logic               rsp_we;
    l2_rsp_t            rsp;

    l2_rr_picker #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req      (bus.m_req_i),
        .rr_ptr   (rr_ptr),
        .fix_prio (fix_prio_i),
        .gnt      (win_gnt),
        .idx      (win_idx),
        .valid    (win_valid)
    );

    always_comb begin
        sel                    = '0;
        sel.we                 = bus.m_we_i[win_idx];
        sel.be                 = bus.m_be_i[win_idx];
        sel.addr[ADDR_W-1:0]   = bus.m_addr_i[win_idx];
        sel.wdata              = bus.m_wdata_i[win_idx];
    end

    assign off         = sel.addr[ADDR_W-1:0] - BASE_ADDR;
    assign in_range    = (sel.addr[ADDR_W-1:0] >= BASE_ADDR) && ({1'b0, off[ADDR_W-1:2]} < MEM_WORDS_L);
    assign unused_bits = ^off[1:0];

    // Grants are suppressed while reset is asserted so nothing reaches the SRAM.
    assign grant           = win_valid && !rst_i;
    assign bus.m_gnt_o     = grant ? win_gnt : '0;
    assign bus.mem_req_o   = grant && in_range;
    assign bus.mem_we_o    = sel.we;
    assign bus.mem_be_o    = sel.be;
    assign bus.mem_addr_o  = off[2 +: MAW];
    assign bus.mem_wdata_o = sel.wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_err   <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= grant;
            if (grant) begin
                rsp_idx <= win_idx;
                rsp_err <= !in_range;
                rsp_we  <= sel.we;
                rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_comb begin
        rsp.rvalid = rsp_valid;
        rsp.err    = rsp_valid && rsp_err;
        if (!rsp_valid || (rsp_we && !rsp_err)) rsp.rdata = '0;
        else if (rsp_err)                       rsp.rdata = ERR_RDATA;
        else                                    rsp.rdata = bus.mem_rdata_i;
    end

    always_comb begin
        bus.m_rvalid_o = '0;
        bus.m_rdata_o  = '0;
        bus.m_err_o    = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                bus.m_rvalid_o[i] = rsp.rvalid;
                bus.m_rdata_o[i]  = rsp.rdata;
                bus.m_err_o[i]    = rsp.err;
            end
        end
    end

endmodule
